core_mc: RTL and testbench
==========================

Name: core_mc

Overview:
- Multicycle accumulator core; parametrised successor of the single-cycle core.
- Fetches instructions from an external instruction memory over a req/ack handshake and executes them through an internal accumulator, register file, ALU and flags.
- Adds conditional and unconditional branches, zero/carry flags, an output port and halt.
- Sits at the top of the CPU, between instruction memory and the testbench/IO.

Parameters:
- ADDR_WIDTH, 5, PC and instruction-memory address width; also the opcode field width.
- REG_BIT_CNT, 3, register-select width; the register file holds 2^REG_BIT_CNT words.
- DATA_WIDTH, 16, accumulator, register, immediate and output width.
- COMBINED_DATA, ADDR_WIDTH+REG_BIT_CNT+DATA_WIDTH, instruction word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_ext  in  1  synchronous reset, active-high.
- imem_addr  out  ADDR_WIDTH  fetch address, equal to the PC.
- imem_req  out  1  fetch request; high iff state==FETCH.
- imem_ack  in  1  instruction valid this cycle.
- imem_data  in  COMBINED_DATA  instruction word {opcode, reg, imm}.
- out_data  out  DATA_WIDTH  last value written by OUT.
- out_valid  out  1  one-cycle pulse per OUT.
- halted  out  1  core stopped.
- acc_out  out  DATA_WIDTH  accumulator, for debug.

Behaviour:
- Reset state: state=FETCH, pc=0, acc=0, all registers=0, Z=0, C=0, IR=0, out_data=0, out_valid=0, halted=0.
- Reset is synchronous: rst_ext sampled high at an edge overrides everything, including an outstanding fetch or HALT.
- Instruction fields: op=IR[top ADDR_WIDTH bits], rsel=next REG_BIT_CNT bits, imm=low DATA_WIDTH bits.
- Operand select: if op MSB=1, operand=imm; otherwise operand=reg[rsel].
- Opcode function: op low 4 bits (ADDR_WIDTH=5).
- FSM FETCH: imem_req=1, imem_addr=pc.
  - imem_ack=0: hold; pc and imem_addr stable.
  - imem_ack=1: IR<=imem_data, go to EXEC.
- FSM EXEC (one cycle): perform the op, update pc, go to FETCH; HALT goes to HALT instead.
  - Minimum 2 cycles per instruction with same-cycle ack.
- FSM HALT: imem_req=0, halted=1, stays in HALT until rst_ext.
- Opcodes (Z updated from the new acc on every op that writes acc; C updated only where stated):
  - 0 NOP.
  - 1 LD: acc<=operand.
  - 2 ST: reg[rsel]<=acc; ignores the operand-select bit.
  - 3 ADD: {C,acc}<=acc+operand (DATA_WIDTH+1 bits).
  - 4 SUB: acc<=acc-operand mod 2^DATA_WIDTH; C<=(acc<operand), the borrow.
  - 5 AND, 6 OR, 7 XOR: bitwise; C unchanged.
  - 8 SHL: C<=acc MSB, acc<=acc<<1.
  - 9 SHR: C<=acc LSB, acc<=acc>>1 (logical).
  - 10 JMP: pc<=operand[ADDR_WIDTH-1:0].
  - 11 JZ: jump if Z=1.
  - 12 JC: jump if C=1.
  - 13 OUT: out_data<=acc, out_valid=1 for the cycle after EXEC.
  - 14 HALT.
  - 15 reserved, see Optional Feature.
- Branches test the flags as they were before the branch; a taken branch does not increment the pc.
- PC: non-branch ops and not-taken branches set pc<=pc+1. The pc wraps from 2^ADDR_WIDTH-1 to 0.
- imem_data is ignored outside FETCH, and ack outside FETCH is ignored.
- No hazards: the register read and the write occur in the same EXEC. A following instruction sees the updated value.

Optional Feature:
- Macro CORE_MC_MUL_EN.
- Defined: opcode 15 = MUL. Full product P=acc*operand (2*DATA_WIDTH bits); acc<=P low half, C<=|P high half, Z updated.
- Undefined: opcode 15 behaves as NOP; no flags or state change except pc+1.

Test Plan:
- Reset then ack every cycle, program: LD #5; ADD #3; OUT; HALT. Required: out_valid pulses once with out_data=8; halted=1; imem_req=0; exactly 8 cycles from reset release to halted.
- LD #0xFFFF; ADD #1; JC 6. Required: acc=0, Z=1, C=1; next imem_addr=6.
- LD #3; ST r2; LD #0; LD r2; SUB #4. Required: acc=0xFFFF, C=1, Z=0.
- Ack withheld 5 cycles on the first fetch. Required: imem_req held high, imem_addr=0 stable, no state change; execution resumes on ack.
- PC=31 fetching a NOP. Required: next imem_addr=0. Also assert rst_ext during a stalled fetch: next cycle pc=0, acc=0, state FETCH.
- LD #300; MUL #300. With CORE_MC_MUL_EN: acc=0x5F90, C=1. Without it: acc=300, C unchanged.

Source files
------------

// File: rtl/core_mc.sv
// Multicycle accumulator core: fetch over req/ack, execute via acc/regfile/ALU/flags; CORE_MC_MUL_EN enables MUL on opcode 15.
// Latency: 2 cycles per instruction minimum (FETCH + EXEC); OUT pulses out_valid the cycle after its EXEC.
// Backpressure: the core waits in FETCH with imem_req high and pc frozen until imem_ack.
module core_mc #(
    parameter int ADDR_WIDTH    = 5,
    parameter int REG_BIT_CNT   = 3,
    parameter int DATA_WIDTH    = 16,
    parameter int COMBINED_DATA = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_ext,
    output logic [ADDR_WIDTH-1:0]    imem_addr,
    output logic                     imem_req,
    input  logic                     imem_ack,
    input  logic [COMBINED_DATA-1:0] imem_data,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    output logic                     halted,
    output logic [DATA_WIDTH-1:0]    acc_out
);

    localparam int NREGS = 2 ** REG_BIT_CNT;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  op;
        logic [REG_BIT_CNT-1:0] rsel;
        logic [DATA_WIDTH-1:0]  imm;
    } instr_t;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] F_NOP  = 4'd0;
    localparam logic [3:0] F_LD   = 4'd1;
    localparam logic [3:0] F_ST   = 4'd2;
    localparam logic [3:0] F_ADD  = 4'd3;
    localparam logic [3:0] F_SUB  = 4'd4;
    localparam logic [3:0] F_AND  = 4'd5;
    localparam logic [3:0] F_OR   = 4'd6;
    localparam logic [3:0] F_XOR  = 4'd7;
    localparam logic [3:0] F_SHL  = 4'd8;
    localparam logic [3:0] F_SHR  = 4'd9;
    localparam logic [3:0] F_JMP  = 4'd10;
    localparam logic [3:0] F_JZ   = 4'd11;
    localparam logic [3:0] F_JC   = 4'd12;
    localparam logic [3:0] F_OUT  = 4'd13;
    localparam logic [3:0] F_HALT = 4'd14;
    localparam logic [3:0] F_MUL  = 4'd15;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   pc, pc_nxt;
    logic [DATA_WIDTH-1:0]   acc, acc_nxt;
    logic                    z_flag, z_nxt;
    logic                    c_flag, c_nxt;
    instr_t                  ir, ir_nxt;
    logic [DATA_WIDTH-1:0]   regs [NREGS];
    logic                    reg_we;
    logic                    out_load;
    logic                    acc_wr;
    logic [3:0]              func;
    logic [DATA_WIDTH-1:0]   operand;
    logic [ADDR_WIDTH-1:0]   target;
    logic [DATA_WIDTH:0]     sum;

    // Opcode MSB selects the immediate; otherwise the addressed register.
    assign func    = ir.op[3:0];
    assign operand = ir.op[ADDR_WIDTH-1] ? ir.imm : regs[ir.rsel];
    assign target  = operand[ADDR_WIDTH-1:0];
    assign sum     = {1'b0, acc} + {1'b0, operand};

`ifdef CORE_MC_MUL_EN
    logic [2*DATA_WIDTH-1:0] product;
    assign product = {{DATA_WIDTH{1'b0}}, acc} * {{DATA_WIDTH{1'b0}}, operand};
`endif

    assign imem_addr = pc;
    assign halted    = (state == S_HALT);
    assign acc_out   = acc;

    always_ff @(posedge clk) begin
        if (rst_ext) begin
            state     <= S_FETCH;
            pc        <= '0;
            acc       <= '0;
            z_flag    <= 1'b0;
            c_flag    <= 1'b0;
            ir        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            acc       <= acc_nxt;
            z_flag    <= z_nxt;
            c_flag    <= c_nxt;
            ir        <= ir_nxt;
            out_valid <= out_load;
            if (out_load) begin
                out_data <= acc;
            end
            if (reg_we) begin
                regs[ir.rsel] <= acc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        acc_nxt   = acc;
        z_nxt     = z_flag;
        c_nxt     = c_flag;
        ir_nxt    = ir;
        reg_we    = 1'b0;
        out_load  = 1'b0;
        acc_wr    = 1'b0;
        imem_req  = 1'b0;

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_nxt    = instr_t'(imem_data);
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                pc_nxt    = pc + ADDR_WIDTH'(1);
                case (func)
                    F_NOP: ;
                    F_LD: begin
                        acc_nxt = operand;
                        acc_wr  = 1'b1;
                    end
                    F_ST:  reg_we = 1'b1;
                    F_ADD: begin
                        {c_nxt, acc_nxt} = sum;
                        acc_wr           = 1'b1;
                    end
                    F_SUB: begin
                        acc_nxt = acc - operand;
                        c_nxt   = (acc < operand);
                        acc_wr  = 1'b1;
                    end
                    F_AND: begin
                        acc_nxt = acc & operand;
                        acc_wr  = 1'b1;
                    end
                    F_OR: begin
                        acc_nxt = acc | operand;
                        acc_wr  = 1'b1;
                    end
                    F_XOR: begin
                        acc_nxt = acc ^ operand;
                        acc_wr  = 1'b1;
                    end
                    F_SHL: begin
                        c_nxt   = acc[DATA_WIDTH-1];
                        acc_nxt = {acc[DATA_WIDTH-2:0], 1'b0};
                        acc_wr  = 1'b1;
                    end
                    F_SHR: begin
                        c_nxt   = acc[0];
                        acc_nxt = {1'b0, acc[DATA_WIDTH-1:1]};
                        acc_wr  = 1'b1;
                    end
                    F_JMP: pc_nxt = target;
                    F_JZ: begin
                        if (z_flag) pc_nxt = target;
                    end
                    F_JC: begin
                        if (c_flag) pc_nxt = target;
                    end
                    F_OUT:  out_load  = 1'b1;
                    F_HALT: state_nxt = S_HALT;
`ifdef CORE_MC_MUL_EN
                    F_MUL: begin
                        acc_nxt = product[DATA_WIDTH-1:0];
                        c_nxt   = |product[2*DATA_WIDTH-1:DATA_WIDTH];
                        acc_wr  = 1'b1;
                    end
`else
                    F_MUL: ;
`endif
                    default: ;
                endcase
                if (acc_wr) begin
                    z_nxt = (acc_nxt == '0);
                end
            end
            S_HALT: ;
            default: state_nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_core_mc.sv
// Directed bench for core_mc: small programs in a behavioural instruction memory, checked against hand-computed results.
module tb_core_mc;

    localparam int AW = 5;
    localparam int RW = 3;
    localparam int DW = 16;
    localparam int CW = AW + RW + DW;

    logic          clk = 1'b0;
    logic          rst_ext = 1'b1;
    logic [AW-1:0] imem_addr;
    logic          imem_req;
    logic          imem_ack = 1'b1;
    logic [CW-1:0] imem_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          halted;
    logic [DW-1:0] acc_out;

    logic [CW-1:0] mem [32];

    int n_chk  = 0;
    int n_pass = 0;
    int trace[$];
    int outs[$];
    int cycles;

    core_mc dut (
        .clk       (clk),
        .rst_ext   (rst_ext),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .acc_out   (acc_out)
    );

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    localparam logic [3:0] NOP = 4'd0, LD = 4'd1, ST = 4'd2, ADD = 4'd3, SUB = 4'd4,
                           AND = 4'd5, OR = 4'd6, XOR = 4'd7, SHL = 4'd8, SHR = 4'd9,
                           JMP = 4'd10, JZ = 4'd11, JC = 4'd12, OUT = 4'd13, HLT = 4'd14,
                           MUL = 4'd15;

    function automatic logic [CW-1:0] ii(input logic [3:0] f, input logic [DW-1:0] imm);
        return {1'b1, f, 3'd0, imm};
    endfunction

    function automatic logic [CW-1:0] ir(input logic [3:0] f, input logic [RW-1:0] r);
        return {1'b0, f, r, 16'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        rst_ext = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_ext = 1'b0;
    endtask

    // Runs until halted, logging fetch addresses and OUT values; cycles counts edges to halt.
    task automatic run_prog(input int budget);
        trace.delete();
        outs.delete();
        cycles = 0;
        while (!halted && cycles < budget) begin
            if (imem_req && imem_ack) trace.push_back(int'(imem_addr));
            @(posedge clk);
            #1;
            cycles++;
            if (out_valid) outs.push_back(int'(out_data));
        end
        if (!halted) check("timeout", 32'(cycles), 32'(budget + 1));
    endtask

    initial begin
        // Reset state
        clr_mem();
        do_reset();
        check("rst_req", 32'(imem_req), 1);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_acc", 32'(acc_out), 0);
        check("rst_outv", 32'(out_valid), 0);
        check("rst_outd", 32'(out_data), 0);
        check("rst_halt", 32'(halted), 0);

        // LD #5; ADD #3; OUT; HALT
        mem[0] = ii(LD, 16'd5);
        mem[1] = ii(ADD, 16'd3);
        mem[2] = ir(OUT, 3'd0);
        mem[3] = ir(HLT, 3'd0);
        do_reset();
        run_prog(40);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid) outs.push_back(int'(out_data));
        end
        check("t1_cycles", 32'(cycles), 8);
        check("t1_npulse", 32'(outs.size()), 1);
        check("t1_out", 32'(outs[0]), 8);
        check("t1_halt", 32'(halted), 1);
        check("t1_req", 32'(imem_req), 0);

        // Reset out of HALT
        do_reset();
        check("halt_rst", 32'(halted), 0);

        // LD #FFFF; ADD #1; JC 6 -> 6: JZ 10 -> 10: OUT; HALT
        clr_mem();
        mem[0]  = ii(LD, 16'hFFFF);
        mem[1]  = ii(ADD, 16'd1);
        mem[2]  = ii(JC, 16'd6);
        mem[3]  = ir(HLT, 3'd0);
        mem[6]  = ii(JZ, 16'd10);
        mem[7]  = ir(HLT, 3'd0);
        mem[10] = ir(OUT, 3'd0);
        mem[11] = ir(HLT, 3'd0);
        do_reset();
        run_prog(60);
        check("t2_jc_tgt", 32'(trace[3]), 6);
        check("t2_jz_tgt", 32'(trace[4]), 10);
        check("t2_acc", 32'(acc_out), 0);
        check("t2_nfetch", 32'(trace.size()), 6);

        // LD #3; ST r2; LD #0; LD r2; SUB #4 -> FFFF, C=1 (JC taken), Z=0 (JZ not taken)
        clr_mem();
        mem[0]  = ii(LD, 16'd3);
        mem[1]  = ir(ST, 3'd2);
        mem[2]  = ii(LD, 16'd0);
        mem[3]  = ir(LD, 3'd2);
        mem[4]  = ii(SUB, 16'd4);
        mem[5]  = ii(JC, 16'd8);
        mem[6]  = ir(HLT, 3'd0);
        mem[8]  = ii(JZ, 16'd12);
        mem[9]  = ir(OUT, 3'd0);
        mem[10] = ir(HLT, 3'd0);
        mem[12] = ir(HLT, 3'd0);
        do_reset();
        run_prog(60);
        check("t3_acc", 32'(acc_out), 32'hFFFF);
        check("t3_jc_tgt", 32'(trace[6]), 8);
        check("t3_jz_nt", 32'(trace[7]), 9);
        check("t3_out", 32'(outs[0]), 32'hFFFF);

        // Ack withheld 5 cycles on first fetch
        clr_mem();
        mem[0] = ii(LD, 16'd7);
        mem[1] = ir(OUT, 3'd0);
        mem[2] = ir(HLT, 3'd0);
        imem_ack = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_req", 32'(imem_req), 1);
            check("stall_addr", 32'(imem_addr), 0);
            check("stall_acc", 32'(acc_out), 0);
        end
        imem_ack = 1'b1;
        run_prog(40);
        check("stall_cyc", 32'(cycles), 6);
        check("stall_out", 32'(outs[0]), 7);

        // PC wrap 31 -> 0 on NOP; second visit to 0 sees C=1
        clr_mem();
        mem[0]  = ii(JC, 16'd5);
        mem[1]  = ii(LD, 16'hFFFF);
        mem[2]  = ii(ADD, 16'd1);
        mem[3]  = ii(JMP, 16'd31);
        mem[5]  = ir(HLT, 3'd0);
        mem[31] = ir(NOP, 3'd0);
        do_reset();
        run_prog(60);
        check("wrap_31", 32'(trace[4]), 31);
        check("wrap_0", 32'(trace[5]), 0);
        check("wrap_jc", 32'(trace[6]), 5);

        // Reset asserted during a stalled fetch
        clr_mem();
        mem[0] = ii(LD, 16'h55);
        mem[1] = ir(HLT, 3'd0);
        do_reset();
        @(posedge clk);
        #1 imem_ack = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_acc", 32'(acc_out), 32'h55);
        check("pre_rst_pc", 32'(imem_addr), 1);
        @(posedge clk);
        #1 rst_ext = 1'b1;
        @(posedge clk);
        #1 rst_ext = 1'b0;
        check("stl_rst_acc", 32'(acc_out), 0);
        check("stl_rst_pc", 32'(imem_addr), 0);
        check("stl_rst_req", 32'(imem_req), 1);
        imem_ack = 1'b1;

        // Logic and shift ops
        clr_mem();
        mem[0]  = ii(LD, 16'h00F0);
        mem[1]  = ii(OR, 16'h0F00);
        mem[2]  = ii(XOR, 16'h00FF);
        mem[3]  = ir(SHL, 3'd0);
        mem[4]  = ir(OUT, 3'd0);
        mem[5]  = ii(LD, 16'h8001);
        mem[6]  = ir(SHR, 3'd0);
        mem[7]  = ii(AND, 16'h7000);
        mem[8]  = ii(JC, 16'd10);
        mem[9]  = ir(HLT, 3'd0);
        mem[10] = ir(OUT, 3'd0);
        mem[11] = ir(SHL, 3'd0);
        mem[12] = ir(SHL, 3'd0);
        mem[13] = ii(JZ, 16'd15);
        mem[14] = ir(HLT, 3'd0);
        mem[15] = ir(HLT, 3'd0);
        do_reset();
        run_prog(80);
        check("alu_out0", 32'(outs[0]), 32'h1E1E);
        check("alu_out1", 32'(outs[1]), 32'h4000);
        check("alu_jc", 32'(trace[9]), 10);
        check("alu_last", 32'(trace[trace.size()-1]), 15);
        check("alu_acc", 32'(acc_out), 0);

        // LD #300; MUL #300
        clr_mem();
        mem[0] = ii(LD, 16'd300);
        mem[1] = ii(MUL, 16'd300);
        mem[2] = ii(JC, 16'd5);
        mem[3] = ir(OUT, 3'd0);
        mem[4] = ir(HLT, 3'd0);
        mem[5] = ir(OUT, 3'd0);
        mem[6] = ir(HLT, 3'd0);
        do_reset();
        run_prog(40);
`ifdef CORE_MC_MUL_EN
        check("mul_acc", 32'(acc_out), 32'h5F90);
        check("mul_c", 32'(trace[3]), 5);
`else
        check("mul_acc", 32'(acc_out), 300);
        check("mul_c", 32'(trace[3]), 3);
`endif
        check("mul_out", 32'(outs[0]), 32'(acc_out));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
